addsub_arbiter: RTL

Sequencing and arbitration controller for the shared 16-bit carry-lookahead add/sub unit. Two requesters issue operations (add/sub, signed/unsigned) over valid/ready handshakes. The block grants one at a time with round-robin priority, registers operands, drives the adder for one cycle, and returns the registered sum and overflow flag over a response handshake tagged with the requester ID. One operation is outstanding at a time.

---
 rtl/addsub_pkg.sv | 25 ++
 rtl/addsub_cla.sv | 34 +++
 rtl/addsub_arbiter.sv | 116 +++++++++++
 3 files changed

// File: rtl/addsub_pkg.sv
// Shared types, widths and carry-lookahead helpers for the add/sub arbiter.
package addsub_pkg;
  localparam int DATA_W  = 16;
  localparam int NUM_REQ = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  // Lookahead carries into bits 1..3 of a 4-wide group from generate/propagate and carry-in.
  function automatic logic [2:0] cla_carry3(input logic [2:0] g, input logic [2:0] p,
                                            input logic ci);
    logic [2:0] c;
    c[0] = g[0] | (p[0] & ci);
    c[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    return c;
  endfunction

  function automatic logic grp_gen(input logic [3:0] g, input logic [3:0] p);
    return g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  endfunction
endpackage

// File: rtl/addsub_cla.sv
// 16-bit two-level carry-lookahead adder/subtractor: sub=1 inverts B and injects carry-in.
module addsub_cla
  import addsub_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              sub,
  output logic [DATA_W-1:0] sum,
  output logic              cout
);
  localparam int NGRP = DATA_W / 4;

  logic [DATA_W-1:0] b_x, g, p, c;
  logic [NGRP-1:0]   gg, pg, cin_grp;

  always_comb begin
    b_x = b ^ {DATA_W{sub}};
    g   = a & b_x;
    p   = a ^ b_x;
    for (int k = 0; k < NGRP; k++) begin
      gg[k] = grp_gen(g[4*k +: 4], p[4*k +: 4]);
      pg[k] = &p[4*k +: 4];
    end
    // Second lookahead level produces the carry into each 4-bit group.
    cin_grp = {cla_carry3(gg[2:0], pg[2:0], sub), sub};
    c = '0;
    for (int k = 0; k < NGRP; k++) begin
      c[4*k]       = cin_grp[k];
      c[4*k+1 +: 3] = cla_carry3(g[4*k +: 3], p[4*k +: 3], cin_grp[k]);
    end
    sum  = p ^ c;
    cout = grp_gen(gg, pg) | (&pg & sub);
  end
endmodule

// File: rtl/addsub_arbiter.sv
// Round-robin arbiter and sequencer for the shared add/sub unit; one op in flight.
// IDLE: grant a requester | EXEC: adder runs on latched operands | RESP: hold response
module addsub_arbiter
  import addsub_pkg::*;
#(
  parameter logic PRIO_INIT = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req_valid,
  output logic [NUM_REQ-1:0] req_ready,
  input  logic [DATA_W-1:0]  req_a0,
  input  logic [DATA_W-1:0]  req_b0,
  input  logic [DATA_W-1:0]  req_a1,
  input  logic [DATA_W-1:0]  req_b1,
  input  logic [NUM_REQ-1:0] req_sub,
  input  logic [NUM_REQ-1:0] req_sign,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic               rsp_id,
  output logic [DATA_W-1:0]  rsp_sum,
  output logic               rsp_ovf,
  output logic               busy
);
  state_e            state_q, state_d;
  logic              prio_q, prio_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic              sub_q, sub_d, sign_q, sign_d, id_q, id_d, ovf_q, ovf_d;

  logic              grant_id;
  logic [DATA_W-1:0] add_sum;
  logic              add_cout, b_msb, sgn_ovf, uns_ovf, ovf_calc;

  addsub_cla u_cla (
    .a    (a_q),
    .b    (b_q),
    .sub  (sub_q),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // Unsigned subtract has no carry-out exactly when A < B.
  always_comb begin
    b_msb    = b_q[DATA_W-1] ^ sub_q;
    sgn_ovf  = (a_q[DATA_W-1] == b_msb) && (add_sum[DATA_W-1] != a_q[DATA_W-1]);
    uns_ovf  = sub_q ? ~add_cout : add_cout;
    ovf_calc = sign_q ? sgn_ovf : uns_ovf;
  end

  always_comb begin
    state_d   = state_q;
    prio_d    = prio_q;
    a_d       = a_q;
    b_d       = b_q;
    sub_d     = sub_q;
    sign_d    = sign_q;
    id_d      = id_q;
    sum_d     = sum_q;
    ovf_d     = ovf_q;
    req_ready = '0;
    grant_id  = (&req_valid) ? prio_q : req_valid[1];
    case (state_q)
      IDLE: begin
        if (|req_valid) begin
          req_ready[grant_id] = 1'b1;
          a_d     = grant_id ? req_a1 : req_a0;
          b_d     = grant_id ? req_b1 : req_b0;
          sub_d   = req_sub[grant_id];
          sign_d  = req_sign[grant_id];
          id_d    = grant_id;
          prio_d  = ~grant_id;
          state_d = EXEC;
        end
      end
      EXEC: begin
        sum_d   = add_sum;
        ovf_d   = ovf_calc;
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      prio_q  <= PRIO_INIT;
      a_q     <= '0;
      b_q     <= '0;
      sub_q   <= 1'b0;
      sign_q  <= 1'b0;
      id_q    <= 1'b0;
      sum_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sub_q   <= sub_d;
      sign_q  <= sign_d;
      id_q    <= id_d;
      sum_q   <= sum_d;
      ovf_q   <= ovf_d;
    end
  end

  assign rsp_valid = (state_q == RESP);
  assign busy      = (state_q != IDLE);
  assign rsp_id    = id_q;
  assign rsp_sum   = sum_q;
  assign rsp_ovf   = ovf_q;
endmodule
